// File: rtl/pulse_gap_meter_pkg.sv
// Shared definitions for the pulse/gap meter: FSM state encoding and the
// default run-counter width (also intended for the upstream pattern generator).
package pulse_gap_meter_pkg;

  localparam int DEFAULT_CW = 8;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    ARM  = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } meter_state_e;

endpackage

// File: rtl/pulse_gap_meter_run_counter.sv
// Saturating run-length counter: start loads 1, inc adds 1 until all-ones.
module run_counter
  import pulse_gap_meter_pkg::*;
#(
  parameter int CW = DEFAULT_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          at_max
);

  localparam logic [CW-1:0] MAX_COUNT = '1;

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // start has priority so a new run always begins at 1, never wraps on overflow
  always_comb begin
    count_d = count_q;
    if (start) begin
      count_d = CW'(1);
    end else if (inc && (count_q != MAX_COUNT)) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  assign at_max = (count_q == MAX_COUNT);

endmodule

// File: rtl/pulse_gap_meter.sv
// Measures high-run (pulse) and low-run (gap) lengths of a serial PWM waveform
// and reports each complete period with a one-cycle valid strobe.
module pulse_gap_meter
  import pulse_gap_meter_pkg::*;
#(
  parameter int CW = DEFAULT_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sig,
  output logic [CW-1:0] pulse_len,
  output logic [CW-1:0] gap_len,
  output logic          valid,
  output logic          sat,
  output logic          locked
);

  meter_state_e state_q, state_d;

  logic          h_start, h_inc, h_at_max;
  logic          l_start, l_inc, l_at_max;
  logic [CW-1:0] h_count, l_count;
  logic          report;
  logic          sat_new;

  logic [CW-1:0] pulse_len_q, pulse_len_d;
  logic [CW-1:0] gap_len_q, gap_len_d;
  logic          valid_q, valid_d;
  logic          sat_q, sat_d;
  logic          locked_q, locked_d;
  logic          have_prev_q, have_prev_d;

  run_counter #(.CW(CW)) u_high_cnt (
    .clk    (clk),
    .reset  (reset),
    .start  (h_start),
    .inc    (h_inc),
    .count  (h_count),
    .at_max (h_at_max)
  );

  run_counter #(.CW(CW)) u_low_cnt (
    .clk    (clk),
    .reset  (reset),
    .start  (l_start),
    .inc    (l_inc),
    .count  (l_count),
    .at_max (l_at_max)
  );

  // SYNC discards any high run already in progress; a report only fires on the
  // rising sample that ends a low run, and that same sample starts the next pulse.
  always_comb begin
    state_d = state_q;
    h_start = 1'b0;
    h_inc   = 1'b0;
    l_start = 1'b0;
    l_inc   = 1'b0;
    report  = 1'b0;
    unique case (state_q)
      SYNC: begin
        if (!sig) state_d = ARM;
      end
      ARM: begin
        if (sig) begin
          state_d = HIGH;
          h_start = 1'b1;
        end
      end
      HIGH: begin
        if (sig) begin
          h_inc = 1'b1;
        end else begin
          state_d = LOW;
          l_start = 1'b1;
        end
      end
      LOW: begin
        if (!sig) begin
          l_inc = 1'b1;
        end else begin
          state_d = HIGH;
          h_start = 1'b1;
          report  = 1'b1;
        end
      end
      default: state_d = SYNC;
    endcase
  end

  always_comb begin
    sat_new     = h_at_max | l_at_max;
    pulse_len_d = pulse_len_q;
    gap_len_d   = gap_len_q;
    valid_d     = 1'b0;
    sat_d       = sat_q;
    locked_d    = locked_q;
    have_prev_d = have_prev_q;
    if (report) begin
      pulse_len_d = h_count;
      gap_len_d   = l_count;
      valid_d     = 1'b1;
      sat_d       = sat_new;
      locked_d    = ~sat_new & (h_count == pulse_len_q) &
                    (l_count == gap_len_q) & have_prev_q;
      have_prev_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SYNC;
      pulse_len_q <= '0;
      gap_len_q   <= '0;
      valid_q     <= 1'b0;
      sat_q       <= 1'b0;
      locked_q    <= 1'b0;
      have_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pulse_len_q <= pulse_len_d;
      gap_len_q   <= gap_len_d;
      valid_q     <= valid_d;
      sat_q       <= sat_d;
      locked_q    <= locked_d;
      have_prev_q <= have_prev_d;
    end
  end

  assign pulse_len = pulse_len_q;
  assign gap_len   = gap_len_q;
  assign valid     = valid_q;
  assign sat       = sat_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_pulse_gap_meter.sv
// Directed bench for pulse_gap_meter: rotating PWM patterns, reset cases,
// constant-level holds, and a narrow-counter saturation instance.
module tb_pulse_gap_meter;

  logic       clk = 1'b0;
  logic       reset;
  logic       sig;
  logic       sig3;

  logic [7:0] pulse_len, gap_len;
  logic       valid, sat, locked;
  logic [2:0] pulse_len3, gap_len3;
  logic       valid3, sat3, locked3;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pulse_gap_meter #(.CW(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .sig       (sig),
    .pulse_len (pulse_len),
    .gap_len   (gap_len),
    .valid     (valid),
    .sat       (sat),
    .locked    (locked)
  );

  pulse_gap_meter #(.CW(3)) dut3 (
    .clk       (clk),
    .reset     (reset),
    .sig       (sig3),
    .pulse_len (pulse_len3),
    .gap_len   (gap_len3),
    .valid     (valid3),
    .sat       (sat3),
    .locked    (locked3)
  );

  task automatic test_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    sig   = 1'b0;
    sig3  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({pulse_len, gap_len, valid, sat, locked} !== 19'd0) begin
      n_err++;
      $display("[TB] FAIL reset_state: got pulse=%0d gap=%0d valid=%b sat=%b locked=%b, expected all 0",
               pulse_len, gap_len, valid, sat, locked);
    end
    n_cmp++;
    if ({pulse_len3, gap_len3, valid3, sat3, locked3} !== 9'd0) begin
      n_err++;
      $display("[TB] FAIL reset_state_cw3: got pulse=%0d gap=%0d valid=%b sat=%b locked=%b, expected all 0",
               pulse_len3, gap_len3, valid3, sat3, locked3);
    end
    reset = 1'b0;
  endtask

  // Plays pat MSB-first, cyclically; optionally ignores the first report, which
  // belongs to the previous pattern's last period.
  task automatic test_pattern(input string name, input logic [15:0] pat, input int n_cycles,
                              input int exp_pulse, input int exp_gap, input int exp_count,
                              input bit skip_first);
    int seen    = 0;
    int checked = 0;
    int last    = -1;
    for (int i = 0; i < n_cycles; i++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        if (last >= 0) begin
          n_cmp++;
          if ((i - last) !== (exp_pulse + exp_gap)) begin
            n_err++;
            $display("[TB] FAIL %s_interval: got %0d cycles between valids, expected %0d",
                     name, i - last, exp_pulse + exp_gap);
          end
        end
        last = i;
        if (!(skip_first && (seen == 0))) begin
          n_cmp++;
          if (pulse_len !== exp_pulse[7:0] || gap_len !== exp_gap[7:0] ||
              sat !== 1'b0 || locked !== (checked > 0)) begin
            n_err++;
            $display("[TB] FAIL %s_report%0d: got pulse=%0d gap=%0d sat=%b locked=%b, expected pulse=%0d gap=%0d sat=0 locked=%b",
                     name, checked, pulse_len, gap_len, sat, locked, exp_pulse, exp_gap, checked > 0);
          end
          checked++;
        end
        seen++;
      end
      sig = pat[15 - (i % 16)];
    end
    n_cmp++;
    if (seen !== exp_count) begin
      n_err++;
      $display("[TB] FAIL %s_count: got %0d valids, expected %0d", name, seen, exp_count);
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] seq_bits;
    seq_bits = 10'b1110011001;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      sig = 1'b1;
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({pulse_len, gap_len, valid, sat, locked} !== 19'd0) begin
      n_err++;
      $display("[TB] FAIL mid_reset_clear: got pulse=%0d gap=%0d valid=%b sat=%b locked=%b, expected all 0",
               pulse_len, gap_len, valid, sat, locked);
    end
    reset = 1'b0;
    for (int j = 0; j < 10; j++) begin
      sig = seq_bits[9 - j];
      @(posedge clk);
      #1;
      n_cmp++;
      if (valid !== (j == 9)) begin
        n_err++;
        $display("[TB] FAIL mid_reset_valid_step%0d: got valid=%b, expected %b", j, valid, j == 9);
      end
    end
    n_cmp++;
    if (pulse_len !== 8'd2 || gap_len !== 8'd2 || sat !== 1'b0 || locked !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL mid_reset_first_report: got pulse=%0d gap=%0d sat=%b locked=%b, expected 2 2 0 0",
               pulse_len, gap_len, sat, locked);
    end
    sig = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (valid !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL low_step_valid: got valid=%b, expected 0", valid);
    end
    sig   = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({pulse_len, gap_len, valid, sat, locked} !== 19'd0) begin
      n_err++;
      $display("[TB] FAIL reset_on_report_edge: got pulse=%0d gap=%0d valid=%b sat=%b locked=%b, expected all 0",
               pulse_len, gap_len, valid, sat, locked);
    end
    reset = 1'b0;
  endtask

  task automatic test_hold();
    logic [5:0] seq_bits;
    int bad_hi = 0;
    int bad_lo = 0;
    seq_bits = 6'b010001;
    for (int j = 0; j < 6; j++) begin
      sig = seq_bits[5 - j];
      @(posedge clk);
      #1;
      n_cmp++;
      if (valid !== (j == 5)) begin
        n_err++;
        $display("[TB] FAIL hold_setup_valid_step%0d: got valid=%b, expected %b", j, valid, j == 5);
      end
    end
    n_cmp++;
    if (pulse_len !== 8'd1 || gap_len !== 8'd3 || sat !== 1'b0 || locked !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL hold_setup_report: got pulse=%0d gap=%0d sat=%b locked=%b, expected 1 3 0 0",
               pulse_len, gap_len, sat, locked);
    end
    sig = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (valid !== 1'b0 || pulse_len !== 8'd1 || gap_len !== 8'd3 || sat !== 1'b0 || locked !== 1'b0) begin
        n_err++;
        bad_hi++;
        if (bad_hi <= 3)
          $display("[TB] FAIL hold_high_cycle%0d: got valid=%b pulse=%0d gap=%0d sat=%b locked=%b, expected 0 1 3 0 0",
                   i, valid, pulse_len, gap_len, sat, locked);
      end
    end
    sig = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (valid !== 1'b0 || pulse_len !== 8'd1 || gap_len !== 8'd3 || sat !== 1'b0 || locked !== 1'b0) begin
        n_err++;
        bad_lo++;
        if (bad_lo <= 3)
          $display("[TB] FAIL hold_low_cycle%0d: got valid=%b pulse=%0d gap=%0d sat=%b locked=%b, expected 0 1 3 0 0",
                   i, valid, pulse_len, gap_len, sat, locked);
      end
    end
  endtask

  task automatic test_saturation();
    logic [15:0] pat;
    int seen = 0;
    int last = -1;
    pat = 16'hFFE0;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk);
      #1;
      if (valid3) begin
        if (last >= 0) begin
          n_cmp++;
          if ((i - last) !== 16) begin
            n_err++;
            $display("[TB] FAIL sat_interval: got %0d cycles between valids, expected 16", i - last);
          end
        end
        last = i;
        n_cmp++;
        if (pulse_len3 !== 3'd7 || gap_len3 !== 3'd5 || sat3 !== 1'b1 || locked3 !== 1'b0) begin
          n_err++;
          $display("[TB] FAIL sat_report%0d: got pulse=%0d gap=%0d sat=%b locked=%b, expected 7 5 1 0",
                   seen, pulse_len3, gap_len3, sat3, locked3);
        end
        seen++;
      end
      sig3 = pat[15 - (i % 16)];
    end
    n_cmp++;
    if (seen !== 3) begin
      n_err++;
      $display("[TB] FAIL sat_count: got %0d valids, expected 3", seen);
    end
  endtask

  initial begin
    reset = 1'b1;
    sig   = 1'b0;
    sig3  = 1'b0;
    test_reset();
    test_pattern("p1010",   16'b1010101010101010, 48,  1,  1, 23, 1'b0);
    test_pattern("p1100",   16'b1100110011001100, 48,  2,  2, 12, 1'b1);
    test_pattern("p4_4",    16'b1111000011110000, 48,  4,  4,  6, 1'b1);
    test_pattern("p1_7",    16'b1000000010000000, 48,  1,  7,  6, 1'b1);
    test_pattern("p3_13",   16'b1110000000000000, 48,  3, 13,  3, 1'b1);
    test_pattern("p11_5",   16'b1111111111100000, 48, 11,  5,  3, 1'b1);
    test_reset_mid();
    test_hold();
    test_reset();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
